// File: rtl/sersub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Step count N = WIDTH/DIGIT; the step counter must be able to hold N.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sersub_state_t;

    function automatic int sersub_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int sersub_cnt_w(input int width, input int digit);
        return $clog2(sersub_steps(width, digit) + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit underflows.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor, DIGIT bits per cycle, valid/ready on both sides.
// Optional signed-overflow output ovf is built when SERSUB_OVF_EN is defined.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = sersub_steps(WIDTH, DIGIT);
    localparam int CW = sersub_cnt_w(WIDTH, DIGIT);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    // in/out handshakes: a transfer happens on a rising edge where valid and ready are both high.
    sersub_state_t    state, state_next;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic             brw;
    logic [DIGIT-1:0] slice_d, chain_bi, chain_bo;
    logic             last_step;

    assign last_step = (step == CW'(N - 1));

    for (genvar k = 0; k < DIGIT; k++) begin : g_cell
        if (k == 0) begin : g_first
            assign chain_bi[k] = brw;
        end else begin : g_rest
            assign chain_bi[k] = chain_bo[k-1];
        end
        fs_cell u_cell (
            .x  (a_sh[k]),
            .y  (b_sh[k]),
            .bi (chain_bi[k]),
            .d  (slice_d[k]),
            .bo (chain_bo[k])
        );
    end

    // Result slices enter at the MSB end so after N steps the LSB slice sits at bit 0.
    if (DIGIT == WIDTH) begin : g_res_full
        assign res_next = slice_d;
    end else begin : g_res_shift
        assign res_next = {slice_d, res_sh[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step       <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= borrow_in;
                        step <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    brw    <= chain_bo[DIGIT-1];
                    step   <= step + CW'(1);
                    if (last_step) begin
                        diff       <= res_next;
                        borrow_out <= chain_bo[DIGIT-1];
`ifdef SERSUB_OVF_EN
                        // On the last step cell DIGIT-1 is the MSB of the word.
                        ovf        <= chain_bi[DIGIT-1] ^ chain_bo[DIGIT-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors on DIGIT=2, plus DIGIT=1 and DIGIT=8 streams.
// Build with SERSUB_OVF_EN defined to also check the ovf output.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- main DUT, DIGIT = 2 (N = 4) ----------------
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00, diff;
    logic       borrow_in = 1'b0, borrow_out, busy;
`ifdef SERSUB_OVF_EN
    logic       ovf;
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy)
`ifdef SERSUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic start_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic bi);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bi;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = ~x;
        b         = ~y;
        borrow_in = ~bi;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_borrow"}, borrow_out, eb);
`ifdef SERSUB_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("note: %s unused ovf", tag);
`endif
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic eo);
        start_op(tag, x, y, bi);
        wait_result(tag, ed, eb, eo);
        handshake(tag);
    endtask

    // ---------------- DIGIT = 1 and DIGIT = 8 streams ----------------
    localparam int OPS = 1000;

    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int DG = (g == 0) ? 1 : 8;
        localparam int NS = 8 / DG;

        logic       rr_n = 1'b0, iv = 1'b0, ir, ov, ordy = 1'b0;
        logic [7:0] ia = 8'h00, ib = 8'h00, od;
        logic       ibin = 1'b0, obo, obusy;
        logic       fin = 1'b0;
        logic [8:0] exp_q[$];
`ifdef SERSUB_OVF_EN
        logic       oovf;
        logic       ovf_q[$];
`endif

        serial_subtractor #(.WIDTH(8), .DIGIT(DG)) u_dut (
            .clk        (clk),
            .rst_n      (rr_n),
            .in_valid   (iv),
            .in_ready   (ir),
            .a          (ia),
            .b          (ib),
            .borrow_in  (ibin),
            .out_valid  (ov),
            .out_ready  (ordy),
            .diff       (od),
            .borrow_out (obo),
            .busy       (obusy)
`ifdef SERSUB_OVF_EN
            ,
            .ovf        (oovf)
`endif
        );

        initial begin
            logic [7:0] x, y;
            logic       bi;
            logic [8:0] e;
            int         lat, st, sres;
            repeat (3) @(negedge clk);
            rr_n = 1'b1;
            for (int i = 0; i < OPS; i++) begin
                x  = 8'($urandom_range(0, 255));
                y  = 8'($urandom_range(0, 255));
                bi = 1'($urandom_range(0, 1));
                check($sformatf("d%0d_in_ready", DG), ir, 1);
                iv = 1'b1; ia = x; ib = y; ibin = bi;
                exp_q.push_back({1'b0, x} - {1'b0, y} - {8'd0, bi});
`ifdef SERSUB_OVF_EN
                sres = int'($signed(x)) - int'($signed(y)) - int'(bi);
                ovf_q.push_back(sres < -128 || sres > 127);
`else
                sres = 0;
`endif
                @(posedge clk);
                #1;
                iv = 1'b0; ia = ~x; ib = ~y; ibin = ~bi;
                lat = 0;
                while (!ov && lat < 40) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check($sformatf("d%0d_latency", DG), lat, NS);
                e = exp_q.pop_front();
                check($sformatf("d%0d_diff a=%0h b=%0h bi=%0d", DG, x, y, bi), od, e[7:0]);
                check($sformatf("d%0d_borrow a=%0h b=%0h bi=%0d", DG, x, y, bi), obo, e[8]);
`ifdef SERSUB_OVF_EN
                check($sformatf("d%0d_ovf a=%0h b=%0h bi=%0d", DG, x, y, bi), oovf, ovf_q.pop_front());
`endif
                st = $urandom_range(0, 3);
                repeat (st) begin
                    @(posedge clk);
                    #1;
                end
                ordy = 1'b1;
                @(posedge clk);
                #1;
                ordy = 1'b0;
                check($sformatf("d%0d_no_dup", DG), ov, 0);
            end
            check($sformatf("d%0d_queue_empty", DG), exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("t1", 8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0);
        do_op("t2a", 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0);
        do_op("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op("ov1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        do_op("ov2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        do_op("ov3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Stall the consumer; a stray in_valid pulse must be ignored.
        start_op("bp", 8'hC3, 8'h3C, 1'b0);
        wait_result("bp", 8'h87, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                in_valid = 1'b1; a = 8'h01; b = 8'h02; borrow_in = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_valid_hold", out_valid, 1);
            check("bp_diff_hold", diff, 8'h87);
            check("bp_borrow_hold", borrow_out, 0);
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake("bp");
        check("bp_diff_kept", diff, 8'h87);
        check("bp_busy_idle", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_no_extra_op", {out_valid, busy}, 0);
        end

        // Abort an operation after two BUSY steps.
        start_op("rst", 8'hAA, 8'h55, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        check("abort_busy", busy, 0);
`ifdef SERSUB_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_discarded", {out_valid, busy}, 0);
        end
        do_op("t4", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

        for (int t = 0; t < 60000 && !(g_rand[0].fin && g_rand[1].fin); t++) @(posedge clk);
        check("rand_streams_done", {g_rand[0].fin, g_rand[1].fin}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
